// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared tags and default sizes for the RAM port arbiter
package mem_arb_pkg;

  localparam int AW_DEF         = 9;
  localparam int DW_DEF         = 32;
  localparam int MAX_STARVE_DEF = 4;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_EXT  = 2'd1,
    REQ_LSU  = 2'd2,
    REQ_IFU  = 2'd3
  } req_tag_e;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - fixed-priority grant select: loader, then LSU/fetch with starvation override
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic       ext_req,
  input  logic       lsu_req,
  input  logic       ifu_req,
  input  logic       working,
  input  logic       starve_hit,
  output logic [2:0] gnt_onehot
);

  logic ifu_first;

  always_comb begin
    gnt_onehot = 3'b000;
    ifu_first  = starve_hit && ifu_req;
    if (ext_req) begin
      gnt_onehot[0] = 1'b1;
    end else if (working) begin
      // A starved fetch outranks the LSU for exactly this one decision
      if (lsu_req && !ifu_first) begin
        gnt_onehot[1] = 1'b1;
      end else if (ifu_req) begin
        gnt_onehot[2] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port instruction/data RAM between loader, LSU and fetch
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          working,
  input  logic          ext_req,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  input  logic          lsu_req,
  input  logic          lsu_we,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_gnt,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  input  logic          ifu_req,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_gnt,
  output logic          ifu_rvalid,
  output logic [DW-1:0] ifu_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  req_tag_e      tag1_q, tag1_d;
  req_tag_e      tag2_q, tag2_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          starve_hit;
  logic [2:0]    gnt_onehot;

  assign starve_hit = (starve_q == SW'(MAX_STARVE));

  mem_arb_prio u_prio (
    .ext_req    (ext_req),
    .lsu_req    (lsu_req),
    .ifu_req    (ifu_req),
    .working    (working),
    .starve_hit (starve_hit),
    .gnt_onehot (gnt_onehot)
  );

  // Grants are suppressed while reset is held so no requester sees an acceptance
  assign ext_gnt = gnt_onehot[0] & reset;
  assign lsu_gnt = gnt_onehot[1] & reset;
  assign ifu_gnt = gnt_onehot[2] & reset;

  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag1_d      = REQ_NONE;
    tag2_d      = tag1_q;
    if (ext_gnt) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = ext_addr;
      ram_wdata_d = ext_wdata;
    end else if (lsu_gnt) begin
      ram_en_d    = 1'b1;
      ram_we_d    = lsu_we;
      ram_addr_d  = lsu_addr;
      ram_wdata_d = lsu_wdata;
      tag1_d      = lsu_we ? REQ_NONE : REQ_LSU;
    end else if (ifu_gnt) begin
      ram_en_d    = 1'b1;
      ram_addr_d  = ifu_addr;
      tag1_d      = REQ_IFU;
    end
  end

  always_comb begin
    starve_d = '0;
    if (ifu_req && !ifu_gnt) begin
      starve_d = starve_hit ? starve_q : starve_q + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag1_q      <= REQ_NONE;
      tag2_q      <= REQ_NONE;
      starve_q    <= '0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      starve_q    <= starve_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign lsu_rvalid = (tag2_q == REQ_LSU);
  assign ifu_rvalid = (tag2_q == REQ_IFU);
  assign lsu_rdata  = ram_rdata;
  assign ifu_rdata  = ram_rdata;
  assign busy       = (tag1_q != REQ_NONE) || (tag2_q != REQ_NONE);

endmodule
